// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle sequencer and the MIPS datapath
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       ZeroImm;
    logic       LUI;
    logic       Illegal;

    modport master (
        input  OP, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ZeroImm, LUI, Illegal
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ZeroImm, LUI, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencer for the multicycle MIPS datapath
module multicycle_control #(
    parameter int STATE_W = 4,
    parameter int RA_IDX  = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus,
    output logic [STATE_W-1:0]     State
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADDR = 4'd2,  MEMRD = 4'd3,
        MEMWB   = 4'd4,  MEMWR  = 4'd5,  REXEC   = 4'd6,  IEXEC = 4'd7,
        ALUWB   = 4'd8,  BRANCH = 4'd9,  JUMP    = 4'd10, JAL   = 4'd11
    } state_t;

    localparam logic [5:0] OpR = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04,
                           OpBne = 6'h05, OpAddi = 6'h08, OpAndi = 6'h0c,
                           OpOri = 6'h0d, OpLui = 6'h0f, OpLw = 6'h23, OpSw = 6'h2b;

    // The datapath owns the link-register index; only a sane range is accepted.
    if (RA_IDX < 0 || RA_IDX > 31) begin : gBadRaIdx
        $error("multicycle_control: RA_IDX must be a register index 0..31");
    end

    state_t state, nextState;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    assign State = STATE_W'(state);

    always_comb begin
        nextState    = FETCH;
        bus.PCWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 2'b00;
        bus.MemtoReg = 2'b00;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 3'b000;
        bus.PCSource = 2'b00;
        bus.ZeroImm  = 1'b0;
        bus.LUI      = 1'b0;
        bus.Illegal  = 1'b0;
        // Outputs are forced quiet while reset is held, even though state already reads FETCH.
        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 3'b011;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                    nextState   = bus.MemReady ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ALUOp   = 3'b011;
                    case (bus.OP)
                        OpLw, OpSw:                     nextState = MEMADDR;
                        OpR:                            nextState = REXEC;
                        OpAddi, OpOri, OpAndi, OpLui:   nextState = IEXEC;
                        OpBeq, OpBne:                   nextState = BRANCH;
                        OpJ:                            nextState = JUMP;
                        OpJal:                          nextState = JAL;
                        default:                        bus.Illegal = 1'b1;
                    endcase
                end
                MEMADDR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 3'b011;
                    if (bus.OP == OpLw)      nextState = MEMRD;
                    else if (bus.OP == OpSw) nextState = MEMWR;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    nextState   = bus.MemReady ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 2'b01;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    nextState    = bus.MemReady ? FETCH : MEMWR;
                end
                REXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 3'b111;
                    nextState   = ALUWB;
                end
                IEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    nextState   = ALUWB;
                    case (bus.OP)
                        OpAddi: bus.ALUOp = 3'b011;
                        OpOri:  begin bus.ALUOp = 3'b001; bus.ZeroImm = 1'b1; end
                        OpAndi: begin bus.ALUOp = 3'b000; bus.ZeroImm = 1'b1; end
                        OpLui:  begin bus.ALUOp = 3'b101; bus.LUI = 1'b1; end
                        default: ;
                    endcase
                end
                ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (bus.OP == OpR) ? 2'b01 : 2'b00;
                end
                BRANCH: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = 3'b100;
                    bus.PCSource = 2'b01;
                    bus.PCWrite  = ((bus.OP == OpBeq) && bus.Zero) ||
                                   ((bus.OP == OpBne) && !bus.Zero);
                end
                JUMP: begin
                    bus.PCSource = 2'b10;
                    bus.PCWrite  = 1'b1;
                end
                JAL: begin
                    bus.PCSource = 2'b10;
                    bus.PCWrite  = 1'b1;
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'b10;
                    bus.MemtoReg = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] State;
    int         checks = 0;
    int         errors = 0;

    multicycle_control_if bus ();

    multicycle_control #(.STATE_W(4), .RA_IDX(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .State (State)
    );

    always #5 clk = ~clk;

    // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,ZeroImm,LUI,Illegal}
    function automatic logic [20:0] act_vec();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.ZeroImm, bus.LUI, bus.Illegal};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    endfunction

    // Sequence of phases an instruction walks through, from the opcode table.
    function automatic void phases(input logic [5:0] op, output int q[$]);
        q = {0, 1};
        case (op)
            6'h23: q = {0, 1, 2, 3, 4};
            6'h2b: q = {0, 1, 2, 5};
            6'h00: q = {0, 1, 6, 8};
            6'h08, 6'h0c, 6'h0d, 6'h0f: q = {0, 1, 7, 8};
            6'h04, 6'h05: q = {0, 1, 9};
            6'h02: q = {0, 1, 10};
            6'h03: q = {0, 1, 11};
            default: ;
        endcase
    endfunction

    function automatic logic [20:0] exp_vec(int st, logic [5:0] op, logic z, logic mr);
        logic pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, srca = 0, zi = 0, lui = 0, ill = 0;
        logic [1:0] rdst = 0, m2r = 0, srcb = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (st)
            0:  begin mrd = 1; srcb = 1; aop = 3; irw = mr; pcw = mr; end
            1:  begin srcb = 3; aop = 3; ill = !is_legal(op); end
            2:  begin srca = 1; srcb = 2; aop = 3; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 7; end
            7:  begin
                    srca = 1; srcb = 2;
                    if (op == 6'h08) aop = 3;
                    if (op == 6'h0d) begin aop = 1; zi = 1; end
                    if (op == 6'h0c) begin aop = 0; zi = 1; end
                    if (op == 6'h0f) begin aop = 5; lui = 1; end
                end
            8:  begin rw = 1; rdst = (op == 6'h00) ? 2'd1 : 2'd0; end
            9:  begin srca = 1; aop = 4; pcs = 1; pcw = (op == 6'h04) ? z : (op == 6'h05) ? !z : 1'b0; end
            10: begin pcs = 2; pcw = 1; end
            11: begin pcs = 2; pcw = 1; rw = 1; rdst = 2; m2r = 2; end
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, zi, lui, ill};
    endfunction

    // Runs one instruction from FETCH; entered just after a rising edge with the DUT in FETCH.
    // zmode < 0 randomizes Zero every cycle; fs/ms are MemReady-low cycles in FETCH and MEMRD/MEMWR.
    task automatic run_instr(input logic [5:0] op, input int zmode, input int fs, input int ms);
        int q[$];
        int cycles = 0;
        int latency;
        phases(op, q);
        latency = q.size() + fs + ((op == 6'h23 || op == 6'h2b) ? ms : 0);
        foreach (q[i]) begin
            int n = (q[i] == 0) ? fs + 1 : (q[i] == 3 || q[i] == 5) ? ms + 1 : 1;
            for (int c = 0; c < n; c++) begin
                bus.MemReady = (q[i] == 0 || q[i] == 3 || q[i] == 5) ? (c == n - 1) : 1'($urandom);
                bus.OP       = (q[i] == 0) ? 6'($urandom) : op;
                bus.Zero     = (zmode < 0) ? 1'($urandom) : 1'(zmode);
                @(negedge clk);
                checks++;
                if (State !== 4'(q[i])) begin
                    errors++;
                    $display("FAIL state op=%h cycle=%0d: got %0d expected %0d", op, cycles, State, q[i]);
                end
                checks++;
                if (act_vec() !== exp_vec(q[i], bus.OP, bus.Zero, bus.MemReady)) begin
                    errors++;
                    $display("FAIL outputs op=%h state=%0d: got %b expected %b", op, q[i], act_vec(),
                             exp_vec(q[i], bus.OP, bus.Zero, bus.MemReady));
                end
                cycles++;
                @(posedge clk);
                #1;
            end
        end
        bus.MemReady = 1'b0;
        @(negedge clk);
        checks++;
        if (State !== 4'd0 || cycles != latency) begin
            errors++;
            $display("FAIL latency op=%h: state %0d after %0d cycles, expected FETCH after %0d", op, State, cycles, latency);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.MemReady = 1'b1; bus.OP = 6'h23; bus.Zero = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (State !== 4'd0 || act_vec() !== 21'd0) begin
                errors++;
                $display("FAIL reset_hold: state=%0d outputs=%b expected 0 and all zero", State, act_vec());
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_fetch: IRWrite=%b PCWrite=%b expected 1 1", bus.IRWrite, bus.PCWrite);
        end
        @(posedge clk); #1;
        bus.OP = 6'h02;
        @(negedge clk);
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL reset_decode: state=%0d expected 1", State);
        end
        bus.MemReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();        run_instr(6'h23, -1, 0, 0); endtask
    task automatic test_sw_stall();  run_instr(6'h2b, -1, 0, 2); endtask

    task automatic test_branch();
        run_instr(6'h04, 1, 0, 0);
        run_instr(6'h05, 1, 0, 0);
        run_instr(6'h05, 0, 1, 0);
    endtask

    task automatic test_alu_ops();
        run_instr(6'h0d, -1, 0, 0);
        run_instr(6'h00, -1, 0, 0);
        run_instr(6'h0c, -1, 0, 0);
        run_instr(6'h0f, -1, 0, 0);
        run_instr(6'h08, -1, 2, 0);
    endtask

    task automatic test_jal_illegal();
        run_instr(6'h03, -1, 0, 0);
        run_instr(6'h02, -1, 0, 0);
        run_instr(6'h3f, -1, 0, 0);
    endtask

    task automatic test_mid_reset();
        bus.MemReady = 1'b1; bus.OP = 6'h23;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.MemReady = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (State !== 4'd3) begin
            errors++;
            $display("FAIL mid_reset_setup: state=%0d expected 3", State);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || act_vec() !== 21'd0) begin
            errors++;
            $display("FAIL mid_reset_async: state=%0d outputs=%b expected 0 and all zero", State, act_vec());
        end
        bus.MemReady = 1'b1;
        @(negedge clk);
        checks++;
        if (State !== 4'd0 || act_vec() !== 21'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: state=%0d outputs=%b expected 0 and all zero", State, act_vec());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'h02, -1, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] legal[11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 10)];
            run_instr(op, -1, $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.OP = 6'h00; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_alu_ops();
        test_jal_illegal();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style sequencer that drives the MIPS datapath as a multicycle machine: one shared memory port, one ALU and an instruction register, time-multiplexed over 3–5 states per instruction. It decodes the same opcode set and the same ALUOp encoding as the single-cycle decoder. It adds a memory-ready handshake so instruction and data accesses can stall.

Parameters:
STATE_W, 4, width of the state register and of the State debug output
RA_IDX, 31, register index written by JAL (the datapath uses it when RegDst=10)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH
OP  input  6  Instruction[31:26] from the IR; valid from DECODE until the next FETCH completes
Zero  input  1  ALU zero flag
MemReady  input  1  memory access completes this cycle
PCWrite  output  1  PC load strobe (branch condition already resolved)
IorD  output  1  0 = memory address from PC, 1 = from ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load strobe
RegDst  output  2  00 = rt, 01 = rd, 10 = RA_IDX
MemtoReg  output  2  00 = ALUOut, 01 = MDR, 10 = PC
RegWrite  output  1  register-file write enable
ALUSrcA  output  1  0 = PC, 1 = A register
ALUSrcB  output  2  00 = B, 01 = 4, 10 = extended imm, 11 = sign-ext imm << 2
ALUOp  output  3  000 AND, 001 OR, 011 ADD, 100 SUB, 101 LUI, 111 funct field
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ZeroImm  output  1  zero-extend immediate
LUI  output  1  LUI path select
Illegal  output  1  unsupported opcode detected in DECODE
State  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - State = FETCH (0), asynchronous.
  - While reset is high, every output other than State is 0.
- Defaults: in every state, any output not listed below is 0.
- Transitions occur on the rising edge of clk.
- OP decode is combinational. ADDI=08, ORI=0d, ANDI=0c, LUI=0f, LW=23, SW=2b, BEQ=04, BNE=05, J=02, JAL=03, R=00 (hex).
- FETCH (0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=011.
  - IRWrite = PCWrite = MemReady.
  - If MemReady, go to DECODE; otherwise stay in FETCH.
- DECODE (1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target is latched into ALUOut).
  - Next state: LW/SW to MEMADDR, R to REXEC, ADDI/ORI/ANDI/LUI to IEXEC, BEQ/BNE to BRANCH, J to JUMP, JAL to JAL.
  - Any other opcode: Illegal=1 for this cycle, next state FETCH.
- MEMADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=011. LW goes to MEMRD, SW goes to MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Stay until MemReady, then go to MEMWB.
- MEMWB (4): RegWrite=1, RegDst=00, MemtoReg=01. Next state FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Stay until MemReady, then go to FETCH.
- REXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state ALUWB.
- IEXEC (7): ALUSrcA=1, ALUSrcB=10. Next state ALUWB.
  - ADDI: ALUOp=011.
  - ORI: ALUOp=001, ZeroImm=1.
  - ANDI: ALUOp=000, ZeroImm=1.
  - LUI: ALUOp=101, LUI=1.
- ALUWB (8): RegWrite=1, MemtoReg=00. RegDst=01 if OP=R, else 00. Next state FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01.
  - PCWrite = Zero for BEQ, ~Zero for BNE.
  - Next state FETCH.
- JUMP (10): PCSource=10, PCWrite=1. Next state FETCH.
- JAL (11): PCSource=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. Next state FETCH.
  - PC already holds PC+4, so $31 receives the return address.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Latency in cycles, assuming MemReady is high on first request:
  - 3: branch, J, JAL.
  - 4: R-type, immediate ops, SW.
  - 5: LW.
  - Each cycle MemReady is low adds one cycle.
- MemRead/MemWrite stay asserted and stable for the whole stall. The address select (IorD) does not change during a stall.
- Reset asserted mid-instruction: State returns to FETCH immediately. No further RegWrite, MemWrite or PCWrite strobes are issued.

Test Plan:
- Reset held 3 cycles, then released, MemReady=1 -> State=0 during reset with all strobes 0; first edge after release gives State=1 with IRWrite=PCWrite=1 in the preceding cycle.
- OP=23 (LW), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1, MemtoReg=01 only in state 4.
- OP=2b (SW), MemReady low for 2 cycles in MEMWR -> MemWrite=1, IorD=1 held for 3 cycles; no RegWrite at any point.
- OP=04 with Zero=1, then OP=05 with Zero=1 -> PCWrite=1, PCSource=01 for BEQ; PCWrite=0 for BNE.
- OP=0d (ORI) -> IEXEC shows ALUOp=001, ZeroImm=1; ALUWB shows RegDst=00. OP=00 -> REXEC shows ALUOp=111; ALUWB shows RegDst=01.
- OP=03 (JAL) -> in state 11, RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1. OP=3f -> Illegal=1 in DECODE, then return to FETCH.
